// File: rtl/arm_ctrl_sequencer_pkg.sv
// Shared types for the ARM7 control sequencer: the control word, the sequencer state
// encoding, the instruction classes, and the instruction-field bit positions.
package arm_ctrl_sequencer_pkg;

    typedef enum logic [2:0] {
        S_EXEC1, S_EXEC2, S_EXEC3, S_REFILL1, S_REFILL2
    } seq_state_t;

    typedef enum logic [2:0] {
        CLS_DP_IMM, CLS_DP_REG_IMMSH, CLS_DP_REG_REGSH, CLS_LDR, CLS_STR, CLS_UNSUP
    } instr_class_t;

    typedef enum logic [1:0] {ADDR_NONE, ADDR_PC, ADDR_ALU} addr_src_t;
    typedef enum logic [2:0] {B_NONE, B_IMM, B_REG_RM, B_REG_RS, B_REG_RD, B_READ_DATA} b_src_t;
    typedef enum logic [1:0] {SHSRC_NONE, SHSRC_IMM, SHSRC_REG} shift_src_t;
    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_type_t;
    typedef enum logic [1:0] {WB_NONE, WB_RD, WB_RN} wb_sel_t;

    typedef struct packed {
        addr_src_t   addr_bus_src;
        logic        memory_read_en;
        logic        memory_write_en;
        logic        memory_latch_ir;
        logic        incrementer_writeback;
        b_src_t      b_bus_source;
        logic [11:0] b_bus_imm;
        shift_src_t  shift_source;
        shift_type_t shift_type;
        logic [4:0]  shift_amount;
        logic        latch_shift_amt;
        logic        use_shift_latch;
        logic [3:0]  alu_op;
        logic        alu_set_flags;
        wb_sel_t     alu_writeback;
        logic        pipeline_flush;
    } control_t;

    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_ADD = 4'h4;
    localparam logic [3:0] ALU_MOV = 4'hD;

    localparam int unsigned OPC_HI = 24;
    localparam int unsigned OPC_LO = 21;
    localparam int unsigned U_BIT  = 23;
    localparam int unsigned W_BIT  = 21;
    localparam int unsigned S_BIT  = 20;
    localparam int unsigned L_BIT  = 20;
    localparam int unsigned RD_HI  = 15;
    localparam int unsigned RD_LO  = 12;

    localparam control_t CTRL_NOP = '0;
    localparam control_t CTRL_FETCH = '{
        addr_bus_src: ADDR_PC, memory_read_en: 1'b1, memory_write_en: 1'b0,
        memory_latch_ir: 1'b1, incrementer_writeback: 1'b1, b_bus_source: B_NONE,
        b_bus_imm: 12'h000, shift_source: SHSRC_NONE, shift_type: SH_LSL,
        shift_amount: 5'd0, latch_shift_amt: 1'b0, use_shift_latch: 1'b0,
        alu_op: 4'h0, alu_set_flags: 1'b0, alu_writeback: WB_NONE, pipeline_flush: 1'b0
    };

    // Compare/test opcodes (TST, TEQ, CMP, CMN) only set flags.
    function automatic logic dp_writes_rd(input logic [3:0] opc);
        return opc[3:2] != 2'b10;
    endfunction

    function automatic control_t with_fetch(input control_t c);
        control_t r;
        r = c;
        r.addr_bus_src          = ADDR_PC;
        r.memory_read_en        = 1'b1;
        r.memory_latch_ir       = 1'b1;
        r.incrementer_writeback = 1'b1;
        return r;
    endfunction

    function automatic control_t with_redirect(input control_t c);
        control_t r;
        r = c;
        r.addr_bus_src   = ADDR_ALU;
        r.pipeline_flush = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/arm_instr_classify.sv
// Combinational instruction classifier: sorts an IR into the sequencer's instruction classes
// and flags whether the instruction's final writeback lands in R15.
module arm_instr_classify
    import arm_ctrl_sequencer_pkg::*;
(
    input  logic [31:0]  instr_i,
    output instr_class_t cls_o,
    output logic         writes_pc_o
);

    logic rd_is_pc;
    logic unused_fields;

    assign rd_is_pc      = instr_i[RD_HI:RD_LO] == 4'hF;
    assign unused_fields = ^{instr_i[31:28], instr_i[22:21], instr_i[19:16],
                             instr_i[11:8], instr_i[6:5], instr_i[3:0]};

    always_comb begin
        cls_o       = CLS_UNSUP;
        writes_pc_o = 1'b0;
        if (instr_i[27:25] == 3'b001) begin
            cls_o       = CLS_DP_IMM;
            writes_pc_o = rd_is_pc && dp_writes_rd(instr_i[OPC_HI:OPC_LO]);
        end else if (instr_i[27:25] == 3'b000) begin
            // bit7 & bit4 set is the multiply / extra load-store space
            if (!instr_i[4]) begin
                cls_o       = CLS_DP_REG_IMMSH;
                writes_pc_o = rd_is_pc && dp_writes_rd(instr_i[OPC_HI:OPC_LO]);
            end else if (!instr_i[7]) begin
                cls_o       = CLS_DP_REG_REGSH;
                writes_pc_o = rd_is_pc && dp_writes_rd(instr_i[OPC_HI:OPC_LO]);
            end
        end else if (instr_i[27:25] == 3'b010) begin
            cls_o       = instr_i[L_BIT] ? CLS_LDR : CLS_STR;
            writes_pc_o = instr_i[L_BIT] && rd_is_pc;
        end
    end

endmodule

// File: rtl/arm_ctrl_sequencer.sv
// Multi-cycle ARM7 control sequencer: emits one control word per cycle for DP, LDR/STR and refills.
// Control word is combinational from state and IR; mem_wait freezes state and replays the last word.
module arm_ctrl_sequencer
    import arm_ctrl_sequencer_pkg::*;
#(
    parameter bit NOP_ON_UNDEF = 1'b1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        cond_pass,
    input  logic        mem_wait,
    output control_t    ctrl,
    output logic        instr_done,
    output logic        undef
);

    seq_state_t   state_q, state_d;
    logic [31:0]  ir_q, ir_d;
    logic         post_instr_q, post_instr_d;
    control_t     ctrl_q, ctrl_d, dp_alu;
    logic         done_d, undef_d, finish_dp;
    logic [31:0]  cls_src;
    instr_class_t cls;
    logic         writes_pc;

    // In EXEC1 the live IR is decoded; later cycles work from the latched copy.
    assign cls_src = (state_q == S_EXEC1) ? instr : ir_q;

    arm_instr_classify u_classify (
        .instr_i     (cls_src),
        .cls_o       (cls),
        .writes_pc_o (writes_pc)
    );

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        post_instr_d = post_instr_q;
        ctrl_d       = CTRL_NOP;
        done_d       = 1'b0;
        undef_d      = 1'b0;
        finish_dp    = 1'b0;

        dp_alu               = CTRL_NOP;
        dp_alu.alu_op        = cls_src[OPC_HI:OPC_LO];
        dp_alu.alu_set_flags = cls_src[S_BIT];
        dp_alu.alu_writeback = dp_writes_rd(cls_src[OPC_HI:OPC_LO]) ? WB_RD : WB_NONE;

        case (state_q)
            S_EXEC1: begin
                if (instr_valid) begin
                    ir_d = instr;
                    if (!cond_pass) begin
                        ctrl_d = CTRL_FETCH;
                        done_d = 1'b1;
                    end else begin
                        case (cls)
                            CLS_DP_IMM: begin
                                ctrl_d              = dp_alu;
                                ctrl_d.b_bus_source = B_IMM;
                                ctrl_d.b_bus_imm    = {4'h0, cls_src[7:0]};
                                ctrl_d.shift_source = SHSRC_IMM;
                                ctrl_d.shift_type   = SH_ROR;
                                ctrl_d.shift_amount = {cls_src[11:8], 1'b0};
                                finish_dp           = 1'b1;
                            end
                            CLS_DP_REG_IMMSH: begin
                                ctrl_d              = dp_alu;
                                ctrl_d.b_bus_source = B_REG_RM;
                                ctrl_d.shift_source = SHSRC_IMM;
                                ctrl_d.shift_type   = shift_type_t'(cls_src[6:5]);
                                ctrl_d.shift_amount = cls_src[11:7];
                                finish_dp           = 1'b1;
                            end
                            CLS_DP_REG_REGSH: begin
                                ctrl_d.b_bus_source    = B_REG_RS;
                                ctrl_d.latch_shift_amt = 1'b1;
                                state_d                = S_EXEC2;
                            end
                            CLS_LDR, CLS_STR: begin
                                ctrl_d.b_bus_source  = B_IMM;
                                ctrl_d.b_bus_imm     = cls_src[11:0];
                                ctrl_d.alu_op        = cls_src[U_BIT] ? ALU_ADD : ALU_SUB;
                                ctrl_d.addr_bus_src  = ADDR_ALU;
                                ctrl_d.alu_writeback = cls_src[W_BIT] ? WB_RN : WB_NONE;
                                state_d              = S_EXEC2;
                            end
                            default: begin
                                undef_d = 1'b1;
                                if (NOP_ON_UNDEF) begin
                                    ctrl_d = CTRL_FETCH;
                                    done_d = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            S_EXEC2: begin
                case (cls)
                    CLS_DP_REG_REGSH: begin
                        ctrl_d                 = dp_alu;
                        ctrl_d.b_bus_source    = B_REG_RM;
                        ctrl_d.shift_source    = SHSRC_REG;
                        ctrl_d.use_shift_latch = 1'b1;
                        ctrl_d.shift_type      = shift_type_t'(cls_src[6:5]);
                        finish_dp              = 1'b1;
                    end
                    CLS_LDR: begin
                        ctrl_d.memory_read_en = 1'b1;
                        ctrl_d.b_bus_source   = B_READ_DATA;
                        ctrl_d.alu_op         = ALU_MOV;
                        ctrl_d.alu_writeback  = WB_RD;
                        // A load into PC flushes here and skips the trailing fetch cycle.
                        if (writes_pc) begin
                            ctrl_d.pipeline_flush = 1'b1;
                            post_instr_d          = 1'b1;
                            state_d               = S_REFILL1;
                        end else begin
                            state_d = S_EXEC3;
                        end
                    end
                    CLS_STR: begin
                        ctrl_d.memory_write_en = 1'b1;
                        ctrl_d.b_bus_source    = B_REG_RD;
                        state_d                = S_EXEC3;
                    end
                    default: state_d = S_EXEC1;
                endcase
            end
            S_EXEC3: begin
                ctrl_d  = CTRL_FETCH;
                done_d  = 1'b1;
                state_d = S_EXEC1;
            end
            S_REFILL1: begin
                ctrl_d  = CTRL_FETCH;
                state_d = S_REFILL2;
            end
            S_REFILL2: begin
                ctrl_d       = CTRL_FETCH;
                done_d       = post_instr_q;
                post_instr_d = 1'b0;
                state_d      = S_EXEC1;
            end
            default: state_d = S_REFILL1;
        endcase

        if (finish_dp) begin
            if (writes_pc) begin
                ctrl_d       = with_redirect(ctrl_d);
                post_instr_d = 1'b1;
                state_d      = S_REFILL1;
            end else begin
                ctrl_d  = with_fetch(ctrl_d);
                done_d  = 1'b1;
                state_d = S_EXEC1;
            end
        end
    end

    assign ctrl       = !rst_n ? CTRL_NOP : (mem_wait ? ctrl_q : ctrl_d);
    assign instr_done = done_d & ~mem_wait;
    assign undef      = undef_d & ~mem_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REFILL1;
            ir_q         <= '0;
            post_instr_q <= 1'b0;
            ctrl_q       <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl;
            if (!mem_wait) begin
                state_q      <= state_d;
                ir_q         <= ir_d;
                post_instr_q <= post_instr_d;
            end
        end
    end

endmodule

// File: tb/tb_arm_ctrl_sequencer.sv
// Randomized bench: each instruction is expanded into its expected per-cycle control words
// from the ISA rules, and a negedge process compares the DUT against that list every cycle.
module tb_arm_ctrl_sequencer;
    import arm_ctrl_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        cond_pass = 1'b0;
    logic        mem_wait = 1'b0;
    control_t    ctrl;
    logic        instr_done;
    logic        undef;

    arm_ctrl_sequencer #(.NOP_ON_UNDEF(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .cond_pass   (cond_pass),
        .mem_wait    (mem_wait),
        .ctrl        (ctrl),
        .instr_done  (instr_done),
        .undef       (undef)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        control_t c;
        logic     d;
        logic     u;
    } step_t;

    step_t    exp_q[$];
    control_t exp_ctrl = '0;
    control_t last_ctrl = '0;
    logic     exp_done = 1'b0;
    logic     exp_undef = 1'b0;
    logic     exp_chk = 1'b0;
    int       n_chk = 0;
    int       n_fail = 0;

    always @(negedge clk) begin
        if (exp_chk) begin
            n_chk++;
            if (ctrl !== exp_ctrl || instr_done !== exp_done || undef !== exp_undef) begin
                n_fail++;
                $display("FAIL cycle t=%0t ctrl=%h want %h done=%b want %b undef=%b want %b",
                         $time, ctrl, exp_ctrl, instr_done, exp_done, undef, exp_undef);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    function automatic control_t with_fetch_m(input control_t c);
        control_t r;
        r = c;
        r.addr_bus_src          = ADDR_PC;
        r.memory_read_en        = 1'b1;
        r.memory_latch_ir       = 1'b1;
        r.incrementer_writeback = 1'b1;
        return r;
    endfunction

    function automatic control_t fetch_m();
        control_t z;
        z = '0;
        return with_fetch_m(z);
    endfunction

    task automatic push(input control_t c, input logic d, input logic u);
        step_t s;
        s.c = c;
        s.d = d;
        s.u = u;
        exp_q.push_back(s);
    endtask

    // Final ALU cycle: either normal retire with fetch, or flush plus two refill fetches.
    task automatic finish_m(input control_t c, input bit to_pc);
        control_t r;
        r = c;
        if (to_pc) begin
            r.addr_bus_src   = ADDR_ALU;
            r.pipeline_flush = 1'b1;
            push(r, 1'b0, 1'b0);
            push(fetch_m(), 1'b0, 1'b0);
            push(fetch_m(), 1'b1, 1'b0);
        end else begin
            push(with_fetch_m(r), 1'b1, 1'b0);
        end
    endtask

    task automatic build(input logic [31:0] ir, input bit cp);
        logic [3:0] opc;
        bit         cmp_op, rd_pc, is_dp;
        control_t   c, c1;
        opc    = ir[24:21];
        cmp_op = (opc >= 4'd8) && (opc <= 4'd11);
        rd_pc  = (ir[15:12] == 4'd15);
        is_dp  = (ir[27:25] == 3'b001) || (ir[27:25] == 3'b000 && !(ir[7] && ir[4]));
        exp_q.delete();
        c = '0;
        if (!cp) begin
            push(fetch_m(), 1'b1, 1'b0);
        end else if (is_dp) begin
            c.alu_op        = opc;
            c.alu_set_flags = ir[20];
            c.alu_writeback = cmp_op ? WB_NONE : WB_RD;
            if (ir[25]) begin
                c.b_bus_source = B_IMM;
                c.b_bus_imm    = {4'h0, ir[7:0]};
                c.shift_source = SHSRC_IMM;
                c.shift_type   = SH_ROR;
                c.shift_amount = {ir[11:8], 1'b0};
                finish_m(c, rd_pc && !cmp_op);
            end else if (!ir[4]) begin
                c.b_bus_source = B_REG_RM;
                c.shift_source = SHSRC_IMM;
                c.shift_type   = shift_type_t'(ir[6:5]);
                c.shift_amount = ir[11:7];
                finish_m(c, rd_pc && !cmp_op);
            end else begin
                c1 = '0;
                c1.b_bus_source    = B_REG_RS;
                c1.latch_shift_amt = 1'b1;
                push(c1, 1'b0, 1'b0);
                c.b_bus_source    = B_REG_RM;
                c.shift_source    = SHSRC_REG;
                c.use_shift_latch = 1'b1;
                c.shift_type      = shift_type_t'(ir[6:5]);
                finish_m(c, rd_pc && !cmp_op);
            end
        end else if (ir[27:25] == 3'b010) begin
            c.b_bus_source  = B_IMM;
            c.b_bus_imm     = ir[11:0];
            c.alu_op        = ir[23] ? 4'd4 : 4'd2;
            c.addr_bus_src  = ADDR_ALU;
            c.alu_writeback = ir[21] ? WB_RN : WB_NONE;
            push(c, 1'b0, 1'b0);
            c = '0;
            if (ir[20]) begin
                c.memory_read_en = 1'b1;
                c.b_bus_source   = B_READ_DATA;
                c.alu_op         = 4'd13;
                c.alu_writeback  = WB_RD;
                if (rd_pc) begin
                    c.pipeline_flush = 1'b1;
                    push(c, 1'b0, 1'b0);
                    push(fetch_m(), 1'b0, 1'b0);
                    push(fetch_m(), 1'b1, 1'b0);
                end else begin
                    push(c, 1'b0, 1'b0);
                    push(fetch_m(), 1'b1, 1'b0);
                end
            end else begin
                c.memory_write_en = 1'b1;
                c.b_bus_source    = B_REG_RD;
                push(c, 1'b0, 1'b0);
                push(fetch_m(), 1'b1, 1'b0);
            end
        end else begin
            push(fetch_m(), 1'b1, 1'b1);
        end
    endtask

    task automatic cycle(input control_t c, input logic d, input logic u, input logic mw);
        mem_wait  = mw;
        exp_ctrl  = c;
        exp_done  = d;
        exp_undef = u;
        exp_chk   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] ir, input bit cp, input int stall_at,
                             input int stall_len, input bit rnd);
        step_t e;
        int    idx;
        build(ir, cp);
        instr       = ir;
        instr_valid = 1'b1;
        cond_pass   = cp;
        idx         = 0;
        while (exp_q.size() > 0) begin
            if (idx == stall_at) begin
                repeat (stall_len) cycle(last_ctrl, 1'b0, 1'b0, 1'b1);
            end else if (rnd && $urandom_range(0, 5) == 0) begin
                cycle(last_ctrl, 1'b0, 1'b0, 1'b1);
            end
            e = exp_q.pop_front();
            cycle(e.c, e.d, e.u, 1'b0);
            last_ctrl = e.c;
            // Later cycles must run from the latched IR, so scramble the live one.
            if (idx == 0) begin
                instr       = $urandom;
                instr_valid = 1'b0;
                cond_pass   = 1'($urandom_range(0, 1));
            end
            idx++;
        end
    endtask

    task automatic idle();
        instr       = $urandom;
        instr_valid = 1'b0;
        cycle('0, 1'b0, 1'b0, 1'b0);
        last_ctrl = '0;
    endtask

    task automatic reset_seq(input int n);
        rst_n = 1'b0;
        repeat (n) cycle('0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle(fetch_m(), 1'b0, 1'b0, 1'b0);
        cycle(fetch_m(), 1'b0, 1'b0, 1'b0);
        last_ctrl = fetch_m();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ir;
        ir        = $urandom;
        ir[31:28] = 4'hE;
        if ($urandom_range(0, 3) == 0) ir[15:12] = 4'hF;
        case ($urandom_range(0, 6))
            0: ir[27:25] = 3'b001;
            1: begin ir[27:25] = 3'b000; ir[4] = 1'b0; end
            2: begin ir[27:25] = 3'b000; ir[7] = 1'b0; ir[4] = 1'b1; end
            3: ir[27:25] = 3'b010;
            4: ir[27:25] = 3'b101;
            5: begin ir[27:22] = 6'b000000; ir[7:4] = 4'b1001; end
            default: ir[27] = 1'b1;
        endcase
        return ir;
    endfunction

    initial begin
        reset_seq(3);

        build(32'hE29210FF, 1'b1);
        chk("adds_len", 64'(exp_q.size()), 64'd1);
        chk("adds_imm", 64'(exp_q[0].c.b_bus_imm), 64'h0FF);
        chk("adds_alu", 64'({exp_q[0].c.alu_op, exp_q[0].c.alu_set_flags, exp_q[0].c.alu_writeback}),
            64'({4'h4, 1'b1, 2'd1}));
        chk("adds_fetch", 64'({exp_q[0].c.memory_read_en, exp_q[0].c.memory_latch_ir,
                               exp_q[0].c.incrementer_writeback, exp_q[0].c.addr_bus_src, exp_q[0].d}),
            64'({3'b111, 2'd1, 1'b1}));
        run_instr(32'hE29210FF, 1'b1, -1, 0, 1'b0);

        build(32'hE1A00211, 1'b1);
        chk("regsh_c1", 64'({exp_q[0].c.latch_shift_amt, exp_q[0].c.b_bus_source, exp_q[0].c.alu_writeback}),
            64'({1'b1, 3'd3, 2'd0}));
        chk("regsh_c2", 64'({exp_q[1].c.use_shift_latch, exp_q[1].c.shift_source,
                             exp_q[1].c.alu_writeback, exp_q[1].d}),
            64'({1'b1, 2'd2, 2'd1, 1'b1}));
        run_instr(32'hE1A00211, 1'b1, -1, 0, 1'b0);

        build(32'hE5343008, 1'b1);
        chk("ldr_len", 64'(exp_q.size()), 64'd3);
        chk("ldr_c1", 64'({exp_q[0].c.alu_op, exp_q[0].c.addr_bus_src, exp_q[0].c.alu_writeback,
                           exp_q[0].c.b_bus_imm}),
            64'({4'h2, 2'd2, 2'd2, 12'h008}));
        chk("ldr_c2", 64'({exp_q[1].c.memory_read_en, exp_q[1].c.b_bus_source,
                           exp_q[1].c.alu_writeback, exp_q[1].c.addr_bus_src}),
            64'({1'b1, 3'd5, 2'd1, 2'd0}));
        run_instr(32'hE5343008, 1'b1, 1, 2, 1'b0);

        build(32'hE1A0F000, 1'b1);
        chk("movpc_flush", 64'({exp_q[0].c.pipeline_flush, exp_q[0].c.memory_read_en,
                                exp_q[0].c.memory_latch_ir, exp_q[0].c.addr_bus_src}),
            64'({1'b1, 1'b0, 1'b0, 2'd2}));
        chk("movpc_done", 64'({exp_q[0].d, exp_q[1].d, exp_q[2].d}), 64'b001);
        run_instr(32'hE1A0F000, 1'b1, -1, 0, 1'b0);

        build(32'hE1510002, 1'b0);
        chk("cmp_fail", 64'({exp_q[0].c.alu_writeback, exp_q[0].c.alu_set_flags,
                             exp_q[0].c.memory_latch_ir, exp_q[0].d}),
            64'({2'd0, 1'b0, 1'b1, 1'b1}));
        run_instr(32'hE1510002, 1'b0, -1, 0, 1'b0);

        build(32'hEA000000, 1'b1);
        chk("branch_undef", 64'({exp_q[0].u, exp_q[0].d, exp_q[0].c.memory_latch_ir}), 64'b111);
        run_instr(32'hEA000000, 1'b1, -1, 0, 1'b0);
        idle();

        // Reset in the middle of a load abandons it and refills without a done pulse.
        build(32'hE5343008, 1'b1);
        instr       = 32'hE5343008;
        instr_valid = 1'b1;
        cond_pass   = 1'b1;
        cycle(exp_q[0].c, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        reset_seq(2);

        for (int i = 0; i < 250; i++) begin
            run_instr(rand_instr(), $urandom_range(0, 5) != 0, -1, 0, 1'b1);
            repeat ($urandom_range(0, 2)) idle();
        end

        exp_chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
